// File: rtl/alu_simd_accum_ctrl.sv
// rtl/alu_simd_accum_ctrl.sv - multi-beat SIMD ALU accumulation sequencer (optional ALU_CTRL_STICKY_OVF_EN)
module alu_simd_accum_ctrl #(
    parameter int WIDTH = 54,
    parameter int CW    = 12,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_simd,
    input  logic [3:0]       cmd_alumode,
    input  logic [8:0]       cmd_opmode,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic             cmd_cin,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_w,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    output logic [3:0]       alu_alumode,
    output logic [8:0]       alu_opmode,
    output logic [1:0]       alu_use_simd,
    output logic [WIDTH-1:0] alu_w,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic [WIDTH-1:0] alu_z,
    output logic             alu_cin,
    output logic [CW-1:0]    alu_carry_in,
    input  logic [WIDTH-1:0] alu_s,
    input  logic [CW-1:0]    alu_carry_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [CW-1:0]    res_carry,
    output logic [CW-1:0]    res_ovf,
    output logic             cmd_err,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         simd_q, simd_d;
    logic [3:0]         alumode_q, alumode_d;
    logic [8:0]         opmode_q, opmode_d;
    logic               cin_q, cin_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]      carry_q, carry_d;
    logic               first_q, first_d;
    logic               cmd_err_q, cmd_err_d;

    logic cmd_fire;
    logic cmd_legal;
    logic beat_fire;
    logic last_beat;
    logic res_fire;

    // Handshake qualifiers shared by the FSM and the datapath
    always_comb begin
        cmd_fire  = (state_q == S_IDLE) && cmd_valid;
        cmd_legal = (cmd_simd != 2'b11);
        beat_fire = (state_q == S_RUN) && in_valid;
        last_beat = beat_fire && (remaining_q == CNT_W'(1));
        res_fire  = (state_q == S_DONE) && res_ready;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: IDLE -> RUN on a legal command, RUN -> DONE on last beat, DONE -> IDLE on result handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cmd_fire && cmd_legal) state_d = S_RUN;
            S_RUN:   if (last_beat)             state_d = S_DONE;
            S_DONE:  if (res_fire)              state_d = S_IDLE;
            default:                            state_d = S_IDLE;
        endcase
    end

    // Job context, accumulator, carry chain and beat counter updates
    always_comb begin
        simd_d      = simd_q;
        alumode_d   = alumode_q;
        opmode_d    = opmode_q;
        cin_d       = cin_q;
        remaining_d = remaining_q;
        acc_d       = acc_q;
        carry_d     = carry_q;
        first_d     = first_q;
        cmd_err_d   = cmd_fire && !cmd_legal;
        if (cmd_fire && cmd_legal) begin
            simd_d      = cmd_simd;
            alumode_d   = cmd_alumode;
            opmode_d    = cmd_opmode;
            cin_d       = cmd_cin;
            // A zero length still runs one beat so the job always produces a result
            remaining_d = (cmd_len == '0) ? CNT_W'(1) : cmd_len;
            acc_d       = '0;
            carry_d     = '0;
            first_d     = 1'b1;
        end
        if (beat_fire) begin
            acc_d       = alu_s;
            carry_d     = alu_carry_out;
            first_d     = 1'b0;
            remaining_d = remaining_q - CNT_W'(1);
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            simd_q      <= '0;
            alumode_q   <= '0;
            opmode_q    <= '0;
            cin_q       <= 1'b0;
            remaining_q <= '0;
            acc_q       <= '0;
            carry_q     <= '0;
            first_q     <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            simd_q      <= simd_d;
            alumode_q   <= alumode_d;
            opmode_q    <= opmode_d;
            cin_q       <= cin_d;
            remaining_q <= remaining_d;
            acc_q       <= acc_d;
            carry_q     <= carry_d;
            first_q     <= first_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

`ifdef ALU_CTRL_STICKY_OVF_EN
    logic [CW-1:0] ovf_q, ovf_d;

    // Sticky lane carry: cleared when a job starts, accumulates every accepted beat's carry vector
    always_comb begin
        ovf_d = ovf_q;
        if (cmd_fire && cmd_legal) begin
            ovf_d = '0;
        end
        if (beat_fire) begin
            ovf_d = ovf_q | alu_carry_out;
        end
    end

    // Sticky lane carry register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    // Sticky carry is only visible alongside a valid result
    always_comb begin
        res_ovf = (state_q == S_DONE) ? ovf_q : '0;
    end
`else
    // Without the sticky register the port is tied off
    always_comb begin
        res_ovf = '0;
    end
`endif

    // Outputs: handshakes from state, ALU operands gated to RUN, result gated to DONE
    always_comb begin
        cmd_ready    = (state_q == S_IDLE);
        in_ready     = (state_q == S_RUN);
        busy         = (state_q != S_IDLE);
        cmd_err      = cmd_err_q;
        alu_alumode  = alumode_q;
        alu_opmode   = opmode_q;
        alu_use_simd = simd_q;
        alu_w        = '0;
        alu_x        = '0;
        alu_y        = '0;
        alu_z        = '0;
        alu_cin      = 1'b0;
        alu_carry_in = '0;
        res_valid    = 1'b0;
        res_data     = '0;
        res_carry    = '0;
        if (state_q == S_RUN) begin
            alu_w        = in_w;
            alu_x        = in_x;
            alu_y        = in_y;
            // The first beat starts from a clean accumulator and takes the job's carry-in
            alu_z        = first_q ? '0 : acc_q;
            alu_cin      = first_q ? cin_q : 1'b0;
            alu_carry_in = first_q ? '0 : carry_q;
        end
        if (state_q == S_DONE) begin
            res_valid = 1'b1;
            res_data  = acc_q;
            res_carry = carry_q;
        end
    end

endmodule

// File: tb/tb_alu_simd_accum_ctrl.sv
// tb/tb_alu_simd_accum_ctrl.sv - randomized self-checking bench for alu_simd_accum_ctrl
module tb_alu_simd_accum_ctrl;

    localparam int WIDTH = 54;
    localparam int CW    = 12;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_simd;
    logic [3:0]       cmd_alumode;
    logic [8:0]       cmd_opmode;
    logic [CNT_W-1:0] cmd_len;
    logic             cmd_cin;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_w, in_x, in_y;
    logic [3:0]       alu_alumode;
    logic [8:0]       alu_opmode;
    logic [1:0]       alu_use_simd;
    logic [WIDTH-1:0] alu_w, alu_x, alu_y, alu_z;
    logic             alu_cin;
    logic [CW-1:0]    alu_carry_in;
    logic [WIDTH-1:0] alu_s;
    logic [CW-1:0]    alu_carry_out;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic [CW-1:0]    res_carry;
    logic [CW-1:0]    res_ovf;
    logic             cmd_err;
    logic             busy;

    logic [CW-1:0]    carry_drive;

    int compared = 0;
    int failed   = 0;

    logic [WIDTH-1:0] bw [0:255];
    logic [WIDTH-1:0] bx [0:255];
    logic [WIDTH-1:0] by [0:255];
    logic [CW-1:0]    bc [0:255];

    alu_simd_accum_ctrl #(.WIDTH(WIDTH), .CW(CW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_simd(cmd_simd),
        .cmd_alumode(cmd_alumode), .cmd_opmode(cmd_opmode), .cmd_len(cmd_len), .cmd_cin(cmd_cin),
        .in_valid(in_valid), .in_ready(in_ready), .in_w(in_w), .in_x(in_x), .in_y(in_y),
        .alu_alumode(alu_alumode), .alu_opmode(alu_opmode), .alu_use_simd(alu_use_simd),
        .alu_w(alu_w), .alu_x(alu_x), .alu_y(alu_y), .alu_z(alu_z),
        .alu_cin(alu_cin), .alu_carry_in(alu_carry_in),
        .alu_s(alu_s), .alu_carry_out(alu_carry_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_carry(res_carry), .res_ovf(res_ovf), .cmd_err(cmd_err), .busy(busy)
    );

    // Stand-in ALU: plain sum of all operands; carry vector is whatever the bench dictates
    always_comb begin
        alu_s         = alu_w + alu_x + alu_y + alu_z + WIDTH'(alu_cin);
        alu_carry_out = carry_drive;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            bw[i] = {$urandom, $urandom};
            bx[i] = {$urandom, $urandom};
            by[i] = {$urandom, $urandom};
            bc[i] = CW'($urandom);
        end
    endtask

    // Runs one complete job against the reference sum; gap: 0 none, 1 every other cycle, 2 random
    task automatic do_job(input logic [1:0] simd, input logic [3:0] amode, input logic [8:0] omode,
                          input int len, input logic cin, input int gap, input int hold);
        int n;
        int i;
        bit last_bubble;
        bit bubble;
        logic [WIDTH-1:0] exp_acc;
        logic [CW-1:0]    prev_carry;
        logic [CW-1:0]    exp_ovf;
        logic [CW-1:0]    exp_ovf_port;
        n = (len == 0) ? 1 : len;
        for (int t = 0; t < 20 && cmd_ready !== 1'b1; t++) @(negedge clk);
        compared++;
        if (cmd_ready !== 1'b1) begin failed++; $display("FAIL job_cmd_ready got=%b exp=1", cmd_ready); end
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_simd = simd; cmd_alumode = amode; cmd_opmode = omode;
        cmd_len = CNT_W'(len); cmd_cin = cin;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        compared++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || alu_alumode !== amode || alu_opmode !== omode
            || alu_use_simd !== simd) begin
            failed++;
            $display("FAIL job_start busy=%b in_ready=%b mode=%h/%h/%h exp=1/1/%h/%h/%h",
                     busy, in_ready, alu_alumode, alu_opmode, alu_use_simd, amode, omode, simd);
        end
        @(posedge clk); #1;
        exp_acc = '0; prev_carry = '0; exp_ovf = '0;
        i = 0; last_bubble = 0;
        while (i < n) begin
            bubble = (gap == 1 && !last_bubble) || (gap == 2 && !last_bubble && $urandom_range(0, 2) == 0);
            last_bubble = bubble;
            if (bubble) begin
                in_valid = 1'b0;
                in_w = {$urandom, $urandom};
                carry_drive = CW'($urandom);
                @(negedge clk);
                compared++;
                if (alu_z !== exp_acc || res_valid !== 1'b0) begin
                    failed++;
                    $display("FAIL bubble_hold beat=%0d alu_z=%h res_valid=%b exp=%h/0", i, alu_z, res_valid, exp_acc);
                end
            end else begin
                in_valid = 1'b1; in_w = bw[i]; in_x = bx[i]; in_y = by[i]; carry_drive = bc[i];
                @(negedge clk);
                compared++;
                if (alu_z !== exp_acc || alu_cin !== ((i == 0) ? cin : 1'b0) || alu_carry_in !== prev_carry
                    || alu_w !== bw[i] || alu_x !== bx[i] || alu_y !== by[i] || res_valid !== 1'b0) begin
                    failed++;
                    $display("FAIL beat_drive beat=%0d z=%h cin=%b cy=%h w=%h rv=%b exp z=%h cin=%b cy=%h w=%h rv=0",
                             i, alu_z, alu_cin, alu_carry_in, alu_w, res_valid,
                             exp_acc, (i == 0) ? cin : 1'b0, prev_carry, bw[i]);
                end
                exp_acc = exp_acc + bw[i] + bx[i] + by[i] + ((i == 0) ? WIDTH'(cin) : '0);
                prev_carry = bc[i];
                exp_ovf = exp_ovf | bc[i];
                i++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        carry_drive = CW'($urandom);
`ifdef ALU_CTRL_STICKY_OVF_EN
        exp_ovf_port = exp_ovf;
`else
        exp_ovf_port = '0;
`endif
        @(negedge clk);
        compared++;
        if (res_valid !== 1'b1 || res_data !== exp_acc || res_carry !== prev_carry || res_ovf !== exp_ovf_port
            || in_ready !== 1'b0 || cmd_ready !== 1'b0 || alu_z !== '0) begin
            failed++;
            $display("FAIL result rv=%b data=%h carry=%h ovf=%h in_rdy=%b cmd_rdy=%b z=%h exp 1/%h/%h/%h/0/0/0",
                     res_valid, res_data, res_carry, res_ovf, in_ready, cmd_ready, alu_z,
                     exp_acc, prev_carry, exp_ovf_port);
        end
        // Commands offered while the result waits must be ignored
        cmd_valid = 1'b1; cmd_simd = 2'b00; cmd_len = CNT_W'(3);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            @(negedge clk);
            compared++;
            if (res_valid !== 1'b1 || res_data !== exp_acc || cmd_ready !== 1'b0) begin
                failed++;
                $display("FAIL result_hold cyc=%0d rv=%b data=%h cmd_rdy=%b exp 1/%h/0", h, res_valid, res_data, cmd_ready, exp_acc);
            end
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        compared++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0 || res_data !== '0) begin
            failed++;
            $display("FAIL handshake cmd_rdy=%b busy=%b rv=%b data=%h exp 1/0/0/0", cmd_ready, busy, res_valid, res_data);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_simd = '0; cmd_alumode = '0; cmd_opmode = '0;
        cmd_len = '0; cmd_cin = 1'b0; in_valid = 1'b0; in_w = '0; in_x = '0; in_y = '0;
        res_ready = 1'b0; carry_drive = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        compared++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || cmd_err !== 1'b0) begin
            failed++;
            $display("FAIL reset_ctrl cmd_rdy=%b busy=%b in_rdy=%b err=%b exp 1/0/0/0", cmd_ready, busy, in_ready, cmd_err);
        end
        compared++;
        if (res_valid !== 1'b0 || res_data !== '0 || res_carry !== '0 || res_ovf !== '0) begin
            failed++;
            $display("FAIL reset_res rv=%b data=%h carry=%h ovf=%h exp all 0", res_valid, res_data, res_carry, res_ovf);
        end
        compared++;
        if (alu_z !== '0 || alu_w !== '0 || alu_cin !== 1'b0 || alu_carry_in !== '0 || alu_alumode !== '0
            || alu_opmode !== '0 || alu_use_simd !== '0) begin
            failed++;
            $display("FAIL reset_alu z=%h w=%h cin=%b cy=%h mode=%h/%h/%h exp all 0",
                     alu_z, alu_w, alu_cin, alu_carry_in, alu_alumode, alu_opmode, alu_use_simd);
        end
    endtask

    task automatic test_single_beat();
        bw[0] = '0; bx[0] = WIDTH'(5); by[0] = WIDTH'(7); bc[0] = 12'h0a5;
        do_job(2'b00, 4'b0000, 9'h035, 1, 1'b1, 0, 0);
    endtask

    task automatic test_accumulate_gapped();
        for (int i = 0; i < 4; i++) begin
            bw[i] = '0; bx[i] = WIDTH'(i + 1); by[i] = '0; bc[i] = '0;
        end
        do_job(2'b00, 4'b0000, 9'h000, 4, 1'b0, 1, 1);
    endtask

    task automatic test_carry_chain();
        fill_random(2);
        bc[0] = 12'h555;
        do_job(2'b10, 4'b0011, 9'h1a2, 2, 1'b0, 0, 0);
    endtask

    task automatic test_illegal();
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_simd = 2'b11; cmd_len = CNT_W'(2); in_valid = 1'b1;
        @(negedge clk);
        compared++;
        if (cmd_ready !== 1'b1) begin failed++; $display("FAIL illegal_accept cmd_rdy=%b exp=1", cmd_ready); end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        compared++;
        if (cmd_err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            failed++;
            $display("FAIL illegal_pulse err=%b busy=%b in_rdy=%b exp 1/0/0", cmd_err, busy, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        compared++;
        if (cmd_err !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            failed++;
            $display("FAIL illegal_after err=%b busy=%b cmd_rdy=%b exp 0/0/1", cmd_err, busy, cmd_ready);
        end
    endtask

    task automatic test_backpressure_reset();
        fill_random(3);
        do_job(2'b01, 4'b0000, 9'h033, 3, 1'b1, 0, 5);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_simd = 2'b01; cmd_alumode = 4'hc; cmd_opmode = 9'h155;
        cmd_len = CNT_W'(6); cmd_cin = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        in_valid = 1'b1; in_w = {$urandom, $urandom}; in_x = {$urandom, $urandom}; in_y = '0;
        carry_drive = 12'hfff;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        compared++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || res_valid !== 1'b0
            || alu_z !== '0 || alu_w !== '0 || alu_carry_in !== '0 || alu_alumode !== '0
            || alu_use_simd !== '0 || res_data !== '0) begin
            failed++;
            $display("FAIL midrun_reset cmd_rdy=%b busy=%b in_rdy=%b rv=%b z=%h w=%h cy=%h mode=%h simd=%h data=%h",
                     cmd_ready, busy, in_ready, res_valid, alu_z, alu_w, alu_carry_in, alu_alumode, alu_use_simd, res_data);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        compared++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            failed++;
            $display("FAIL post_reset rv=%b busy=%b cmd_rdy=%b exp 0/0/1", res_valid, busy, cmd_ready);
        end
    endtask

    task automatic test_sticky_ovf();
        fill_random(2);
        bc[0] = 12'h001; bc[1] = 12'h800;
        do_job(2'b10, 4'b0000, 9'h000, 2, 1'b0, 0, 0);
    endtask

    task automatic test_random_jobs();
        for (int j = 0; j < 8; j++) begin
            int len;
            len = $urandom_range(0, 9);
            fill_random(len + 1);
            do_job(2'($urandom_range(0, 2)), 4'($urandom), 9'($urandom), len, 1'($urandom), 2,
                   $urandom_range(0, 3));
        end
    endtask

    task automatic test_max_len();
        fill_random(255);
        do_job(2'b00, 4'b0000, 9'h000, 255, 1'b1, 2, 0);
    endtask

    task automatic test_back_to_back();
        fill_random(2);
        do_job(2'b00, 4'b0001, 9'h011, 2, 1'b0, 0, 0);
        fill_random(1);
        do_job(2'b01, 4'b0010, 9'h022, 0, 1'b1, 0, 0);
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_accumulate_gapped();
        test_carry_chain();
        test_illegal();
        test_backpressure_reset();
        test_sticky_ovf();
        test_back_to_back();
        test_random_jobs();
        test_max_len();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_simd_accum_ctrl.md
Name: alu_simd_accum_ctrl

Overview:
- Sequencer that owns the 54-bit SIMD ALU (27x27 / sum-9x9 / sum-4x4 modes) and runs multi-beat accumulation jobs on it.
- Accepts a job command, streams W/X/Y operand beats into the ALU, and feeds the registered result back as Z.
- Chains the ALU per-lane SIMD carries across beats and returns the final accumulator through a valid/ready result port.
- Sits between the multiplier-array output stage and the DSP result register.

Parameters:
WIDTH, 54, ALU operand/result width
CW, 12, ALU per-lane SIMD carry vector width
CNT_W, 8, beat-count width

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  job command valid
cmd_ready  out  1  high only in IDLE
cmd_simd  in  2  USE_SIMD for job: 00=27x27, 01=sum9x9, 10=sum4x4, 11 illegal
cmd_alumode  in  4  ALUMODE for job
cmd_opmode  in  9  OPMODE for job
cmd_len  in  CNT_W  beats in job; 0 treated as 1
cmd_cin  in  1  CIN applied on first beat only
in_valid  in  1  operand beat valid
in_ready  out  1  high only in RUN
in_w, in_x, in_y  in  WIDTH  operand beat
alu_alumode  out  4  to ALU ALUMODE
alu_opmode  out  9  to ALU OPMODE
alu_use_simd  out  2  to ALU USE_SIMD
alu_w, alu_x, alu_y, alu_z  out  WIDTH  to ALU operands
alu_cin  out  1  to ALU CIN
alu_carry_in  out  CW  to ALU result_SIMD_carry_in
alu_s  in  WIDTH  from ALU S; combinational
alu_carry_out  in  CW  from ALU result_SIMD_carry_out
res_valid  out  1  result valid
res_ready  in  1  result accepted
res_data  out  WIDTH  final accumulator
res_carry  out  CW  carry vector of last beat
res_ovf  out  CW  sticky lane carry; see Optional Feature
cmd_err  out  1  one-cycle pulse on illegal command
busy  out  1  state != IDLE

Behaviour:
- Reset values: all outputs 0, except cmd_ready=1; state=IDLE; acc, carry regs, and beat counter cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - On cmd_valid with cmd_simd != 11: latch simd/alumode/opmode/cin; set remaining = max(cmd_len,1); clear acc and carry regs; set first=1; go to RUN.
  - On cmd_valid with cmd_simd == 11: accept (cmd_ready=1), pulse cmd_err next cycle, stay IDLE.
- ALU drive:
  - alu_alumode/opmode/use_simd come from latched registers; they are constant for the whole job.
  - In IDLE and DONE, alu_w/x/y/z, alu_cin, and alu_carry_in are 0.
- RUN:
  - in_ready=1.
  - alu_w/x/y = in_* passthrough.
  - alu_z = 0 when first, else acc.
  - alu_cin = latched cin when first, else 0.
  - alu_carry_in = carry reg (0 when first).
- Beat accept: when in_valid && in_ready:
  - acc <= alu_s, carry reg <= alu_carry_out, first <= 0, remaining -= 1.
  - No update without in_valid; bubbles are allowed.
- Last beat accept (remaining==1): go to DONE; res_valid=1 the next cycle with res_data=acc, res_carry=carry reg.
  - Latency: result visible 1 cycle after last beat accept.
- DONE:
  - res_data and res_valid are held stable until res_ready.
  - On res_valid && res_ready: go to IDLE; cmd_ready returns 1 in the same cycle as the transition completes (next edge).
  - A new command is not accepted in the handshake cycle.
- Throughput: 1 beat/cycle in RUN; 2 cycles overhead per job (cmd accept, result handshake).
- The ALU is combinational; the controller adds no internal pipelining. acc is the only feedback register.
- Boundaries:
  - in_valid outside RUN is ignored.
  - cmd_valid outside IDLE is ignored (cmd_ready=0).
  - The counter never wraps; len=2^CNT_W-1 is the maximum.
  - rst_n asserted mid-job aborts immediately to the reset state; no partial result is emitted.

Optional Feature:
- Macro ALU_CTRL_STICKY_OVF_EN.
- Defined: a sticky CW-bit register ORs alu_carry_out on every accepted beat. It clears on cmd accept, and res_ovf presents it alongside res_data in DONE.
- Undefined: no register is built; res_ovf is constant 0.

Test Plan:
- Single-beat job: reset, cmd simd=00 alumode=0000 len=1 cin=1, beat w=0 x=5 y=7 -> alu_z=0, alu_cin=1; next cycle res_valid=1, res_data=13.
- Four-beat accumulate: len=4, simd=00, beats x=1,2,3,4 (w=y=0), in_valid gapped every other cycle -> alu_z follows 0,1,3,6; res_data=10; acc unchanged in bubble cycles.
- SIMD carry chaining: simd=10, ALU model returns alu_carry_out=12'h555 on beat 1 -> alu_carry_in=12'h555 on beat 2; res_carry equals beat-2 alu_carry_out.
- Illegal mode: cmd simd=11 -> cmd_err pulses 1 cycle, busy stays 0, in_ready stays 0.
- Backpressure plus reset: hold res_ready=0 for 5 cycles -> res_data stable, cmd_ready=0; then assert rst_n=0 mid-RUN of the next job -> all outputs reset value within the same cycle, cmd_ready=1.
- Sticky overflow (macro defined): carry_out 12'h001 on beat 1 and 12'h800 on beat 2 -> res_ovf=12'h801. Macro undefined -> res_ovf=0.
